// File: rtl/adder_arbiter.sv
// adder_arbiter: four requesters share one WIDTH-bit adder through a
// round-robin arbiter and an IDLE -> EXEC -> DONE sequencer.
// Optional feature: define ADDER_ARB_OVF_EN to register two's-complement
// overflow on rsp_ovf; otherwise rsp_ovf is tied low.
module adder_arbiter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           req,
    input  logic [4*WIDTH-1:0]   op_a,
    input  logic [4*WIDTH-1:0]   op_b,
    input  logic [3:0]           op_cin,
    output logic [3:0]           gnt,
    output logic                 busy,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [1:0]           rsp_id,
    output logic [WIDTH-1:0]     rsp_sum,
    output logic                 rsp_cout,
    output logic                 rsp_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [1:0]         r_last_grant;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_cin;
    logic [1:0]         r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_sum;
    logic               r_rsp_cout;
    logic [1:0]         w_winner;
    logic [1:0]         w_cand;
    logic               w_found;
    logic               w_take;
    logic [WIDTH:0]     w_full;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;

    // Round-robin search starting just after the last granted requester
    always_comb begin
        w_winner = r_last_grant;
        w_found  = 1'b0;
        w_cand   = '0;
        for (int unsigned i = 1; i <= 4; i++) begin
            w_cand = r_last_grant + 2'(i);
            if (!w_found && req[w_cand]) begin
                w_winner = w_cand;
                w_found  = 1'b1;
            end
        end
    end

    // Next-state logic and combinational grant/status outputs
    always_comb begin
        w_state_next = r_state;
        gnt          = '0;
        w_take       = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (|req) begin
                    gnt          = 4'b0001 << w_winner;
                    w_take       = 1'b1;
                    w_state_next = EXEC;
                end
            end
            EXEC: w_state_next = DONE;
            DONE: if (rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    assign busy      = (r_state != IDLE);
    assign rsp_valid = (r_state == DONE);

    // The single shared adder, fed only from the latched operands
    assign w_full = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin};
    assign w_sum  = w_full[WIDTH-1:0];
    assign w_cout = w_full[WIDTH];

    // State register, operand capture on grant, result capture in EXEC
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_last_grant <= 2'd3;
            r_a          <= '0;
            r_b          <= '0;
            r_cin        <= 1'b0;
            r_rsp_id     <= '0;
            r_rsp_sum    <= '0;
            r_rsp_cout   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_take) begin
                r_a          <= op_a[WIDTH*w_winner +: WIDTH];
                r_b          <= op_b[WIDTH*w_winner +: WIDTH];
                r_cin        <= op_cin[w_winner];
                r_last_grant <= w_winner;
            end
            if (r_state == EXEC) begin
                r_rsp_id   <= r_last_grant;
                r_rsp_sum  <= w_sum;
                r_rsp_cout <= w_cout;
            end
        end
    end

    assign rsp_id   = r_rsp_id;
    assign rsp_sum  = r_rsp_sum;
    assign rsp_cout = r_rsp_cout;

`ifdef ADDER_ARB_OVF_EN
    logic r_rsp_ovf;
    logic w_ovf;

    assign w_ovf = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);

    // Signed overflow captured alongside the sum
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rsp_ovf <= 1'b0;
        end else if (r_state == EXEC) begin
            r_rsp_ovf <= w_ovf;
        end
    end

    assign rsp_ovf = r_rsp_ovf;
`else
    assign rsp_ovf = 1'b0;
`endif

endmodule
